// File: rtl/spike_encoder_if.sv
// Handshake/data bundle for spike_encoder: stimulus controls in, spike outputs out.
interface spike_encoder_if;
  logic       ena;
  logic [7:0] intensity;
  logic [3:0] refr;
  logic       seed_load;
  logic [7:0] seed;
  logic       clr_cnt;
  logic       spike;
  logic [7:0] trace;
  logic [7:0] spike_cnt;
  logic       busy;

  modport master (
    output ena, intensity, refr, seed_load, seed, clr_cnt,
    input  spike, trace, spike_cnt, busy
  );

  modport slave (
    input  ena, intensity, refr, seed_load, seed, clr_cnt,
    output spike, trace, spike_cnt, busy
  );
endinterface

// File: rtl/spike_encoder.sv
// Rate-coded spike encoder: an 8-bit Galois LFSR is compared against the
// intensity to decide firing, followed by an optional refractory period.
// Also keeps a decaying pre-synaptic STDP trace and a saturating spike count.
module spike_encoder #(
  parameter int TRACE_SHIFT = 3
) (
  input logic            clk,
  input logic            rst_n,
  spike_encoder_if.slave bus
);

  typedef enum logic {IDLE, REFRACT} state_t;

  state_t     state_q, state_d;
  logic [3:0] rcnt_q, rcnt_d;
  logic [7:0] lfsr_q;
  logic [7:0] trace_q;
  logic [7:0] cnt_q;
  logic       spike_q;
  logic       fire;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return (l >> 1) ^ (l[0] ? 8'hB8 : 8'h00);
  endfunction

  // Shift-based exponential decay; shift of zero still walks a non-zero trace down by one.
  function automatic logic [7:0] trace_decay(input logic [7:0] t);
    logic [7:0] d;
    d = t >> TRACE_SHIFT;
    if (d == 8'd0 && t != 8'd0) return t - 8'd1;
    return t - d;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Fire only when idle, enabled and not reseeding this cycle.
  assign fire = bus.ena && (state_q == IDLE) && !bus.seed_load &&
                (lfsr_q < bus.intensity);

  // Next-state logic for the refractory FSM.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      IDLE: begin
        if (fire && bus.refr != 4'd0) begin
          state_d = REFRACT;
          rcnt_d  = bus.refr;
        end
      end
      REFRACT: begin
        if (bus.ena) begin
          if (rcnt_q == 4'd1) begin
            state_d = IDLE;
            rcnt_d  = 4'd0;
          end else begin
            rcnt_d = rcnt_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        rcnt_d  = 4'd0;
      end
    endcase
  end

  // FSM state and refractory counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // LFSR: reseed has priority over advance; a zero seed would lock up, so map it to 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= 8'h01;
    end else if (bus.ena) begin
      if (bus.seed_load) lfsr_q <= (bus.seed == 8'h00) ? 8'h01 : bus.seed;
      else               lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  // Spike pulse registered one cycle after the fire decision.
  always_ff @(posedge clk) begin
    if (!rst_n) spike_q <= 1'b0;
    else        spike_q <= fire;
  end

  // Trace: jump to full scale on fire, decay on every other enabled cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)       trace_q <= 8'h00;
    else if (fire)    trace_q <= 8'hFF;
    else if (bus.ena) trace_q <= trace_decay(trace_q);
  end

  // Spike counter: clear works even while disabled; a same-cycle fire leaves a count of one.
  always_ff @(posedge clk) begin
    if (!rst_n)           cnt_q <= 8'h00;
    else if (bus.clr_cnt) cnt_q <= fire ? 8'h01 : 8'h00;
    else if (fire)        cnt_q <= sat_inc(cnt_q);
  end

  assign bus.spike     = spike_q;
  assign bus.trace     = trace_q;
  assign bus.spike_cnt = cnt_q;
  assign bus.busy      = (state_q == REFRACT);

endmodule

// File: tb/tb_spike_encoder.sv
// Directed bench for spike_encoder with a cycle-level reference model.
module tb_spike_encoder;

  localparam int SH = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spike_encoder_if bus ();

  spike_encoder #(.TRACE_SHIFT(SH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  int m_lfsr, m_left, m_trace, m_cnt, m_spike;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: evaluates the behavioural rules once per rising edge.
  always @(posedge clk) begin
    int f, dec;
    if (!rst_n) begin
      m_lfsr = 1; m_left = 0; m_trace = 0; m_cnt = 0; m_spike = 0;
    end else begin
      f = (bus.ena && m_left == 0 && !bus.seed_load &&
           m_lfsr < int'(bus.intensity)) ? 1 : 0;
      if (bus.ena) begin
        if (bus.seed_load) m_lfsr = (bus.seed == 0) ? 1 : int'(bus.seed);
        else               m_lfsr = (m_lfsr / 2) ^ ((m_lfsr % 2) * 184);
      end
      if (bus.ena && m_left > 0)      m_left = m_left - 1;
      else if (f == 1 && bus.refr != 0) m_left = int'(bus.refr);
      if (f == 1) m_trace = 255;
      else if (bus.ena) begin
        dec = m_trace / (1 << SH);
        if (dec == 0 && m_trace > 0) dec = 1;
        m_trace = m_trace - dec;
      end
      if (bus.clr_cnt)            m_cnt = f;
      else if (f == 1 && m_cnt < 255) m_cnt = m_cnt + 1;
      m_spike = f;
    end
  end

  // Compare process: all outputs against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("spike", int'(bus.spike), m_spike);
      check("busy", int'(bus.busy), (m_left > 0) ? 1 : 0);
      check("trace", int'(bus.trace), m_trace);
      check("spike_cnt", int'(bus.spike_cnt), m_cnt);
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  int exp_sp [5] = '{1, 0, 0, 0, 1};
  int exp_tr [5] = '{255, 224, 196, 172, 255};

  initial begin
    bus.ena = 1'b1; bus.intensity = 8'hFF; bus.refr = 4'd0;
    bus.seed_load = 1'b1; bus.seed = 8'h55; bus.clr_cnt = 1'b1;
    // Reset must override ena/seed_load/clr_cnt
    rst_n = 1'b0;
    step(2);
    chk_en = 1'b1;
    check("rst_spike", int'(bus.spike), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_trace", int'(bus.trace), 0);
    check("rst_cnt", int'(bus.spike_cnt), 0);

    // LFSR 01,B8,5C,2E,17 against intensity 0x20
    bus.seed_load = 1'b0; bus.clr_cnt = 1'b0;
    bus.intensity = 8'h20; bus.refr = 4'd0; bus.ena = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check($sformatf("rate_spike%0d", i + 1), int'(bus.spike), exp_sp[i]);
      check($sformatf("rate_trace%0d", i + 1), int'(bus.trace), exp_tr[i]);
    end
    check("rate_cnt", int'(bus.spike_cnt), 2);

    // Refractory of 3: fire every 4th cycle
    do_reset();
    bus.intensity = 8'hFF; bus.refr = 4'd3;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      check($sformatf("refr_spike%0d", i), int'(bus.spike), ((i % 4) == 1) ? 1 : 0);
      check($sformatf("refr_busy%0d", i), int'(bus.busy), ((i % 4) != 0) ? 1 : 0);
    end
    // Freeze mid-refractory, counter still has two cycles left
    bus.ena = 1'b0;
    bus.refr = 4'd9;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("frz_busy", int'(bus.busy), 1);
      check("frz_spike", int'(bus.spike), 0);
    end
    bus.ena = 1'b1;
    step(1); check("res_busy1", int'(bus.busy), 1);
    step(1); check("res_busy2", int'(bus.busy), 0);
    bus.refr = 4'd0;
    step(1); check("res_spike", int'(bus.spike), 1);

    // Zero seed maps to 0x01, no fire during the load cycle
    bus.seed_load = 1'b1; bus.seed = 8'h00;
    step(1); check("seed_nospike", int'(bus.spike), 0);
    bus.seed_load = 1'b0;
    step(1); check("seed_fire1", int'(bus.spike), 1);
    bus.intensity = 8'hB8;
    step(1); check("seed_b8_nofire", int'(bus.spike), 0);

    // Zero intensity never fires
    do_reset();
    bus.intensity = 8'h00;
    step(300);
    check("zero_cnt", int'(bus.spike_cnt), 0);
    check("zero_trace", int'(bus.trace), 0);

    // Saturation, then clear on a known fire cycle
    bus.intensity = 8'hFF;
    step(300);
    check("sat_cnt", int'(bus.spike_cnt), 255);
    bus.seed_load = 1'b1; bus.seed = 8'h01;
    step(1);
    bus.seed_load = 1'b0; bus.clr_cnt = 1'b1;
    step(1);
    check("clr_fire_cnt", int'(bus.spike_cnt), 1);
    bus.ena = 1'b0;
    step(1);
    check("clr_noena_cnt", int'(bus.spike_cnt), 0);
    bus.clr_cnt = 1'b0; bus.ena = 1'b1;

    // Reset during a spike pulse and refractory period
    bus.refr = 4'd5;
    bus.seed_load = 1'b1; bus.seed = 8'h01;
    step(1);
    bus.seed_load = 1'b0;
    step(1);
    check("pre_rst_busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    step(1);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_spike", int'(bus.spike), 0);
    check("abort_trace", int'(bus.trace), 0);
    rst_n = 1'b1;
    step(3);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
